// File: rtl/counter_pkg.sv
// Shared constants and parameter-legality helper for the up/down modulo counter family.
package counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   function automatic bit modulo_legal(input int width, input longint modulo);
      return (width >= 32'sd1) && (width <= 32'sd62) &&
             (modulo >= 64'sd2) && (modulo <= (64'sd1 <<< width));
   endfunction

endpackage

// File: rtl/counter_updown_mod_edge_sync_rise.sv
// Two-flop synchronizer plus edge flop; flags each rising edge of an asynchronous level.
module edge_sync_rise (
   input  logic clk,
   input  logic clr_n,
   input  logic async_in,
   output logic step_pulse,
   output logic step_seen
);

   logic s1_r;
   logic s2_r;
   logic s3_r;
   logic seen_r;

   // Shift chain; seen_r is loaded with the next value of step_pulse so both line up.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         s1_r   <= 1'b0;
         s2_r   <= 1'b0;
         s3_r   <= 1'b0;
         seen_r <= 1'b0;
      end else begin
         s1_r   <= async_in;
         s2_r   <= s1_r;
         s3_r   <= s2_r;
         seen_r <= s1_r & ~s2_r;
      end
   end

   assign step_pulse = s2_r & ~s3_r;
   assign step_seen  = seen_r;

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with parallel load, wrap/saturate mode,
// terminal flags and an on-chip step_in synchronizer.
module counter_updown_mod
   import counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULO   = 16,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             step_in,
   input  logic             en,
   input  logic             up,
   input  logic             sclr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             is_all_zero,
   output logic             is_max,
   output logic             wrap,
   output logic             step_seen
);

   localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

   if (!modulo_legal(WIDTH, MODULO)) begin : g_param_check
      $error("counter_updown_mod: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
   end

   logic             step_pulse_s;
   logic             cnt_s;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_next_s;
   logic             wrap_r;
   logic             wrap_next_s;

   edge_sync_rise u_step_sync (
      .clk        (clk),
      .clr_n      (clr_n),
      .async_in   (step_in),
      .step_pulse (step_pulse_s),
      .step_seen  (step_seen)
   );

   // A simultaneous en and step pulse merge into one count.
   assign cnt_s = en | step_pulse_s;

   // Priority mux: sclr, then load, then count, then hold. Bound checks happen
   // before the add/subtract so MODULO = 2**WIDTH never overflows.
   always_comb begin
      q_next_s    = q_r;
      wrap_next_s = 1'b0;
      if (sclr) begin
         q_next_s = ZERO;
      end else if (load) begin
         if (load_val > MAX_VAL) begin
            q_next_s = MAX_VAL;
         end else begin
            q_next_s = load_val;
         end
      end else if (cnt_s) begin
         if (up == DIR_UP) begin
            if (q_r != MAX_VAL) begin
               q_next_s = q_r + ONE;
            end else if (SATURATE) begin
               q_next_s = q_r;
            end else begin
               q_next_s    = ZERO;
               wrap_next_s = 1'b1;
            end
         end else begin
            if (q_r != ZERO) begin
               q_next_s = q_r - ONE;
            end else if (SATURATE) begin
               q_next_s = q_r;
            end else begin
               q_next_s    = MAX_VAL;
               wrap_next_s = 1'b1;
            end
         end
      end else begin
         q_next_s = q_r;
      end
   end

   // Count and wrap registers.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         q_r    <= ZERO;
         wrap_r <= 1'b0;
      end else begin
         q_r    <= q_next_s;
         wrap_r <= wrap_next_s;
      end
   end

   assign q           = q_r;
   assign wrap        = wrap_r;
   assign is_all_zero = (q_r == ZERO);
   assign is_max      = (q_r == MAX_VAL);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Self-checking bench: three counter variants share one directed stimulus and are
// compared every cycle against an arithmetic model, plus hand-computed checkpoints.
module tb_counter_updown_mod;

   localparam int NI = 3;
   localparam int MODS [NI] = '{10, 10, 16};
   localparam bit SATS [NI] = '{1'b0, 1'b1, 1'b0};

   logic       clk = 1'b0;
   logic       clr_n = 1'b0;
   logic       step_in = 1'b0;
   logic       en = 1'b0;
   logic       up = 1'b0;
   logic       sclr = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;

   logic [3:0] q_o    [NI];
   logic       zero_o [NI];
   logic       max_o  [NI];
   logic       wrap_o [NI];
   logic       seen_o [NI];

   int total = 0;
   int bad = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   counter_updown_mod #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) u_dut0 (
      .clk(clk), .clr_n(clr_n), .step_in(step_in), .en(en), .up(up), .sclr(sclr),
      .load(load), .load_val(load_val), .q(q_o[0]), .is_all_zero(zero_o[0]),
      .is_max(max_o[0]), .wrap(wrap_o[0]), .step_seen(seen_o[0]));

   counter_updown_mod #(.WIDTH(4), .MODULO(10), .SATURATE(1'b1)) u_dut1 (
      .clk(clk), .clr_n(clr_n), .step_in(step_in), .en(en), .up(up), .sclr(sclr),
      .load(load), .load_val(load_val), .q(q_o[1]), .is_all_zero(zero_o[1]),
      .is_max(max_o[1]), .wrap(wrap_o[1]), .step_seen(seen_o[1]));

   counter_updown_mod #(.WIDTH(4), .MODULO(16), .SATURATE(1'b0)) u_dut2 (
      .clk(clk), .clr_n(clr_n), .step_in(step_in), .en(en), .up(up), .sclr(sclr),
      .load(load), .load_val(load_val), .q(q_o[2]), .is_all_zero(zero_o[2]),
      .is_max(max_o[2]), .wrap(wrap_o[2]), .step_seen(seen_o[2]));

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // h1/h2/h3: step_in as sampled 1, 2 and 3 edges ago.
   bit h1, h2, h3;
   int mq [NI];
   bit mw [NI];
   bit mseen;

   function automatic int nxt_q(input int q, input int m, input bit sat, input bit c);
      if (sclr)      return 0;
      else if (load) return (int'(load_val) < m) ? int'(load_val) : m - 1;
      else if (!c)   return q;
      else if (up)   return (q < m - 1) ? q + 1 : (sat ? q : 0);
      else           return (q > 0) ? q - 1 : (sat ? q : m - 1);
   endfunction

   function automatic bit nxt_w(input int q, input int m, input bit sat, input bit c);
      return !sclr && !load && c && !sat && (up ? (q == m - 1) : (q == 0));
   endfunction

   always @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         h1 <= 1'b0; h2 <= 1'b0; h3 <= 1'b0; mseen <= 1'b0;
         for (int i = 0; i < NI; i++) begin
            mq[i] <= 0;
            mw[i] <= 1'b0;
         end
      end else begin
         // a rise counted at this edge was first sampled two edges ago
         for (int i = 0; i < NI; i++) begin
            mq[i] <= nxt_q(mq[i], MODS[i], SATS[i], en || (h2 && !h3));
            mw[i] <= nxt_w(mq[i], MODS[i], SATS[i], en || (h2 && !h3));
         end
         mseen <= h1 && !h2;
         h3 <= h2; h2 <= h1; h1 <= step_in;
      end
   end

   // Per-cycle comparison of every output of every variant against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d.q", i), int'(q_o[i]), mq[i]);
            check($sformatf("u%0d.is_all_zero", i), int'(zero_o[i]), int'(mq[i] == 0));
            check($sformatf("u%0d.is_max", i), int'(max_o[i]), int'(mq[i] == MODS[i] - 1));
            check($sformatf("u%0d.wrap", i), int'(wrap_o[i]), int'(mw[i]));
            check($sformatf("u%0d.step_seen", i), int'(seen_o[i]), int'(mseen));
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- directed stimulus with literal checkpoints ----------------
   initial begin
      cyc(2);
      clr_n = 1'b1;
      chk_on = 1'b1;
      check("rst_q", int'(q_o[0]), 0);
      check("rst_zero", int'(zero_o[0]), 1);
      check("rst_max", int'(max_o[0]), 0);
      check("rst_wrap", int'(wrap_o[0]), 0);

      // count a little, then reset asynchronously mid-cycle
      en = 1'b1; up = 1'b1;
      cyc(5);
      check("en_count5", int'(q_o[0]), 5);
      #2 clr_n = 1'b0;
      #1 check("async_rst_q", int'(q_o[0]), 0);
      check("async_rst_zero", int'(zero_o[0]), 1);
      en = 1'b0;
      cyc(1);
      clr_n = 1'b1;

      // three 4-high/4-low step_in pulses
      for (int p = 0; p < 3; p++) begin
         step_in = 1'b1;
         if (p == 0) begin
            cyc(2);
            check("step_lat2_q", int'(q_o[0]), 0);
            check("step_lat2_seen", int'(seen_o[0]), 1);
            cyc(1);
            check("step_lat3_q", int'(q_o[0]), 1);
            cyc(1);
         end else begin
            cyc(4);
         end
         step_in = 1'b0;
         cyc(4);
      end
      check("step3_q", int'(q_o[0]), 3);
      check("step3_q_m16", int'(q_o[2]), 3);

      // wrap up from 8
      load = 1'b1; load_val = 4'd8;
      cyc(1);
      load = 1'b0; en = 1'b1; up = 1'b1;
      check("load8", int'(q_o[0]), 8);
      cyc(1);
      check("up_q9", int'(q_o[0]), 9);
      check("up_max9", int'(max_o[0]), 1);
      cyc(1);
      en = 1'b0;
      check("wrapup_q", int'(q_o[0]), 0);
      check("wrapup_pulse", int'(wrap_o[0]), 1);
      check("sat_up_q", int'(q_o[1]), 9);
      check("sat_up_wrap", int'(wrap_o[1]), 0);
      check("m16_up_q", int'(q_o[2]), 10);
      cyc(1);
      check("wrapup_oneshot", int'(wrap_o[0]), 0);

      // wrap down from 1
      load = 1'b1; load_val = 4'd1;
      cyc(1);
      load = 1'b0; en = 1'b1; up = 1'b0;
      cyc(1);
      check("down_q0", int'(q_o[0]), 0);
      cyc(1);
      en = 1'b0;
      check("wrapdn_q", int'(q_o[0]), 9);
      check("wrapdn_pulse", int'(wrap_o[0]), 1);
      check("sat_dn_q", int'(q_o[1]), 0);
      check("sat_dn_wrap", int'(wrap_o[1]), 0);
      check("m16_dn_q", int'(q_o[2]), 15);

      // load clamp, then sclr beats load and en
      load = 1'b1; load_val = 4'd12;
      cyc(1);
      load = 1'b0;
      check("clamp_q", int'(q_o[0]), 9);
      check("noclamp_m16", int'(q_o[2]), 12);
      sclr = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1;
      cyc(1);
      sclr = 1'b0; load = 1'b0; en = 1'b0;
      check("prio_sclr_q", int'(q_o[0]), 0);
      check("prio_sclr_m16", int'(q_o[2]), 0);

      // en coinciding with step_pulse counts once
      step_in = 1'b1;
      cyc(2);
      en = 1'b1; up = 1'b1;
      cyc(1);
      en = 1'b0;
      check("merge_q", int'(q_o[0]), 1);
      cyc(2);
      step_in = 1'b0;
      cyc(3);
      check("merge_hold_q", int'(q_o[0]), 1);

      // full-width wrap at MODULO = 2**WIDTH
      load = 1'b1; load_val = 4'd15;
      cyc(1);
      load = 1'b0;
      check("full_load15", int'(q_o[2]), 15);
      check("full_max", int'(max_o[2]), 1);
      en = 1'b1; up = 1'b1;
      cyc(1);
      en = 1'b0;
      check("full_wrap_q", int'(q_o[2]), 0);
      check("full_wrap_pulse", int'(wrap_o[2]), 1);
      check("full_q_known", int'($isunknown(q_o[2])), 0);
      cyc(2);

      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
